sync_toggle_counter: RTL and testbench

SYNC_TOGGLE_COUNTER -- requirements
Module: sync_toggle_counter

---
 rtl/sync_toggle_counter.sv | 115 +++++++++++
 tb/tb_sync_toggle_counter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/sync_toggle_counter.sv
// sync_toggle_counter: modulo-MODULUS up/down counter built from per-bit T
// flip-flops. It exposes the toggle vector, a combinational terminal count,
// and a sticky overflow flag.
// Optional feature: define SYNC_TOGGLE_COUNTER_LOAD_EN to compile in the
// parallel load. Without it, LOAD and D are present on the port list but are
// ignored.
`default_nettype none

module sync_toggle_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             EN,
  input  logic             UP,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] D,
  input  logic             OVF_CLR,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qbar,
  output logic [WIDTH-1:0] T_OUT,
  output logic             TC,
  output logic             OVF
);

  // Largest legal count. MODULUS may equal 2^WIDTH, so it is held one bit wider.
  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

  logic [WIDTH-1:0] r_q;
  logic             r_ovf;

  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_tout;
  logic [WIDTH-1:0] w_load_val;
  logic             w_load_act;
  logic             w_step;
  logic             w_tc;

  // Modulo step: wraps at MAX_CNT going up and at zero going down.
  function automatic logic [WIDTH-1:0] f_next_count(
    input logic [WIDTH-1:0] q,
    input logic             up
  );
    logic [WIDTH-1:0] n;
    if (up) begin
      n = (q == MAX_CNT) ? '0 : q + 1'b1;
    end else begin
      n = (q == '0) ? MAX_CNT : q - 1'b1;
    end
    return n;
  endfunction

  // Saturate a load value into the legal count range.
  function automatic logic [WIDTH-1:0] f_clamp_load(
    input logic [WIDTH-1:0] d
  );
    logic [WIDTH-1:0] v;
    v = ({1'b0, d} >= MOD_EXT) ? MAX_CNT : d;
    return v;
  endfunction

`ifdef SYNC_TOGGLE_COUNTER_LOAD_EN
  assign w_load_act = LOAD;
  assign w_load_val = f_clamp_load(D);
`else
  // Load path is absent; the ports are tied off here to keep them visibly consumed.
  logic w_unused_load;
  assign w_unused_load = LOAD ^ (^D);
  assign w_load_act    = 1'b0;
  assign w_load_val    = '0;
`endif

  // A counting step happens only when enabled, not loading and not in reset.
  assign w_step = EN & ~w_load_act & ~CLR;
  assign w_next = f_next_count(r_q, UP);

  // Toggle vector: bits that differ between the current and the next count.
  assign w_tout = w_step ? (r_q ^ w_next) : '0;

  // Terminal count follows the direction sampled this cycle.
  assign w_tc = EN & ~CLR & (UP ? (r_q == MAX_CNT) : (r_q == '0));

  // Per-bit T flip-flops: a bit inverts when its toggle is set; load overrides.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      r_q <= '0;
    end else if (w_load_act) begin
      r_q <= w_load_val;
    end else begin
      r_q <= r_q ^ w_tout;
    end
  end

  // Sticky overflow: set on a taken wrap step, and the set wins over OVF_CLR.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      r_ovf <= 1'b0;
    end else if (w_step & w_tc) begin
      r_ovf <= 1'b1;
    end else if (OVF_CLR) begin
      r_ovf <= 1'b0;
    end
  end

  assign Q     = r_q;
  assign Qbar  = ~r_q;
  assign T_OUT = w_tout;
  assign TC    = w_tc;
  assign OVF   = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_sync_toggle_counter.sv
// Bench for sync_toggle_counter (default WIDTH=4, MODULUS=10): table vectors,
// hand-written corner sequences and random traffic against an arithmetic model.
`timescale 1ns/1ps

module tb_sync_toggle_counter;

  localparam int W   = 4;
  localparam int MOD = 10;

  logic         CLK = 1'b0;
  logic         CLR = 1'b1;
  logic         EN = 1'b0, UP = 1'b1, LOAD = 1'b0, OVF_CLR = 1'b0;
  logic [W-1:0] D = '0;
  logic [W-1:0] Q, Qbar, T_OUT;
  logic         TC, OVF;

  int checks = 0;
  int errors = 0;

  // Model state, kept as plain integers.
  int m_q   = 0;
  int m_ovf = 0;

  // Values captured by the most recent apply() call.
  int pre_tc, pre_tout, post_q, post_ovf;

  sync_toggle_counter #(.WIDTH(W), .MODULUS(MOD)) dut (
    .CLK(CLK), .CLR(CLR), .EN(EN), .UP(UP), .LOAD(LOAD), .D(D),
    .OVF_CLR(OVF_CLR), .Q(Q), .Qbar(Qbar), .T_OUT(T_OUT), .TC(TC), .OVF(OVF)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // Drives one cycle of inputs (called just after a falling edge). It checks
  // the combinational outputs before the rising edge and the registered
  // outputs after it, all against the model.
  task automatic apply(input logic en, input logic up, input logic ld,
                       input logic [W-1:0] d, input logic oc);
    int nxt, e_tc, e_tout, ld_act;
    EN = en; UP = up; LOAD = ld; D = d; OVF_CLR = oc;
`ifdef SYNC_TOGGLE_COUNTER_LOAD_EN
    ld_act = int'(ld);
`else
    ld_act = 0;
`endif
    nxt    = up ? (m_q + 1) % MOD : (m_q + MOD - 1) % MOD;
    e_tc   = (en && (up ? (m_q == MOD - 1) : (m_q == 0))) ? 1 : 0;
    e_tout = (en && ld_act == 0) ? (m_q ^ nxt) : 0;
    #1;
    pre_tc   = int'(TC);
    pre_tout = int'(T_OUT);
    chk("tc", 32'(TC), 32'(e_tc));
    chk("t_out", 32'(T_OUT), 32'(e_tout));
    chk("qbar", 32'(Qbar), 32'((~m_q) & (2**W - 1)));
    @(posedge CLK);
    if (ld_act != 0) begin
      m_q = (int'(d) >= MOD) ? MOD - 1 : int'(d);
    end else if (en) begin
      if (e_tc != 0) m_ovf = 1;
      else if (oc) m_ovf = 0;
      m_q = nxt;
    end else if (oc) begin
      m_ovf = 0;
    end
    if (ld_act != 0 && oc) m_ovf = 0;
    #1;
    post_q   = int'(Q);
    post_ovf = int'(OVF);
    chk("q", 32'(Q), 32'(m_q));
    chk("ovf", 32'(OVF), 32'(m_ovf));
    @(negedge CLK);
  endtask

  typedef struct {
    logic         en;
    logic         up;
    int           e_tc;
    int           e_tout;
    int           e_q;
    int           e_ovf;
  } vec_t;

  vec_t tbl[12];

  initial begin
    // Twelve up-count steps from 0, with the expected values worked out by hand.
    tbl[0]  = '{1'b1, 1'b1, 0, 4'h1, 1, 0};
    tbl[1]  = '{1'b1, 1'b1, 0, 4'h3, 2, 0};
    tbl[2]  = '{1'b1, 1'b1, 0, 4'h1, 3, 0};
    tbl[3]  = '{1'b1, 1'b1, 0, 4'h7, 4, 0};
    tbl[4]  = '{1'b1, 1'b1, 0, 4'h1, 5, 0};
    tbl[5]  = '{1'b1, 1'b1, 0, 4'h3, 6, 0};
    tbl[6]  = '{1'b1, 1'b1, 0, 4'h1, 7, 0};
    tbl[7]  = '{1'b1, 1'b1, 0, 4'hF, 8, 0};
    tbl[8]  = '{1'b1, 1'b1, 0, 4'h1, 9, 0};
    tbl[9]  = '{1'b1, 1'b1, 1, 4'h9, 0, 1};
    tbl[10] = '{1'b1, 1'b1, 0, 4'h1, 1, 1};
    tbl[11] = '{1'b1, 1'b1, 0, 4'h3, 2, 1};

    // Reset state, with the other inputs active and ignored.
    EN = 1'b1; LOAD = 1'b1; D = 4'd7; OVF_CLR = 1'b0;
    repeat (2) @(negedge CLK);
    chk("rst_q", 32'(Q), 32'd0);
    chk("rst_ovf", 32'(OVF), 32'd0);
    chk("rst_qbar", 32'(Qbar), 32'hF);
    chk("rst_tout", 32'(T_OUT), 32'd0);
    chk("rst_tc", 32'(TC), 32'd0);
    EN = 1'b0; LOAD = 1'b0; D = '0;
    CLR = 1'b0;
    @(negedge CLK);

    // Table: wrap from 9 to 0 with TC and OVF.
    for (int i = 0; i < 12; i++) begin
      apply(tbl[i].en, tbl[i].up, 1'b0, '0, 1'b0);
      chk($sformatf("tbl%0d_tc", i), 32'(pre_tc), 32'(tbl[i].e_tc));
      chk($sformatf("tbl%0d_tout", i), 32'(pre_tout), 32'(tbl[i].e_tout));
      chk($sformatf("tbl%0d_q", i), 32'(post_q), 32'(tbl[i].e_q));
      chk($sformatf("tbl%0d_ovf", i), 32'(post_ovf), 32'(tbl[i].e_ovf));
    end

    // Hold with EN=0: Q and OVF stay, T_OUT and TC stay zero.
    apply(1'b0, 1'b1, 1'b0, '0, 1'b0);
    chk("hold_q", 32'(post_q), 32'd2);
    chk("hold_tout", 32'(pre_tout), 32'd0);

    // Count up to 7 with OVF set, then clear asynchronously mid-cycle.
    repeat (5) apply(1'b1, 1'b1, 1'b0, '0, 1'b0);
    chk("pre_clr_q", 32'(Q), 32'd7);
    chk("pre_clr_ovf", 32'(OVF), 32'd1);
    #2 CLR = 1'b1;
    #1;
    chk("aclr_q", 32'(Q), 32'd0);
    chk("aclr_ovf", 32'(OVF), 32'd0);
    chk("aclr_qbar", 32'(Qbar), 32'hF);
    chk("aclr_tout", 32'(T_OUT), 32'd0);
    @(negedge CLK);
    chk("clr_hold_q", 32'(Q), 32'd0);
    CLR = 1'b0;
    m_q = 0; m_ovf = 0;

    // Down count from 0 wraps to 9, then steps to 8.
    apply(1'b1, 1'b0, 1'b0, '0, 1'b0);
    chk("dn_tc", 32'(pre_tc), 32'd1);
    chk("dn_q9", 32'(post_q), 32'd9);
    chk("dn_ovf", 32'(post_ovf), 32'd1);
    apply(1'b1, 1'b0, 1'b0, '0, 1'b0);
    chk("dn_tout9", 32'(pre_tout), 32'd1);
    chk("dn_q8", 32'(post_q), 32'd8);

    // Set wins over OVF_CLR at the wrap; a lone OVF_CLR clears.
    apply(1'b1, 1'b1, 1'b0, '0, 1'b0);
    chk("oc_q9", 32'(post_q), 32'd9);
    apply(1'b1, 1'b1, 1'b0, '0, 1'b1);
    chk("oc_set_wins_q", 32'(post_q), 32'd0);
    chk("oc_set_wins_ovf", 32'(post_ovf), 32'd1);
    apply(1'b0, 1'b1, 1'b0, '0, 1'b1);
    chk("oc_clear_ovf", 32'(post_ovf), 32'd0);
    chk("oc_clear_q", 32'(post_q), 32'd0);

    // Alternate the direction on every edge starting from 4.
    repeat (4) apply(1'b1, 1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      apply(1'b1, (i % 2 == 0), 1'b0, '0, 1'b0);
      chk($sformatf("alt%0d_q", i), 32'(post_q), (i % 2 == 0) ? 32'd5 : 32'd4);
      chk($sformatf("alt%0d_tc", i), 32'(pre_tc), 32'd0);
    end

    // Load strobe.
`ifdef SYNC_TOGGLE_COUNTER_LOAD_EN
    apply(1'b1, 1'b1, 1'b1, 4'd12, 1'b0);
    chk("ld_clamp_q", 32'(post_q), 32'd9);
    chk("ld_clamp_ovf", 32'(post_ovf), 32'd0);
    apply(1'b1, 1'b1, 1'b1, 4'd5, 1'b0);
    chk("ld_q5", 32'(post_q), 32'd5);
`else
    apply(1'b1, 1'b1, 1'b1, 4'd12, 1'b0);
    chk("ld_ignored_q", 32'(post_q), 32'd5);
    apply(1'b0, 1'b1, 1'b1, 4'd2, 1'b0);
    chk("ld_ignored_hold", 32'(post_q), 32'd5);
`endif

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      apply(($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
            ($urandom_range(0, 7) == 0), W'($urandom_range(0, 15)),
            ($urandom_range(0, 5) == 0));
      checks++;
      if (post_q >= MOD) begin
        errors++;
        $display("FAIL range act=%0d exp=<%0d", post_q, MOD);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
